// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: sequencing states, slave indices
// and the GPIO register map.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } apb_state_e;

   localparam logic SLV_GPIO = 1'b0;
   localparam logic SLV_UART = 1'b1;

   localparam int unsigned GPIO_REG_DATA      = 0;
   localparam int unsigned GPIO_REG_DIRECTION = 1;

endpackage

// File: rtl/apb_slave_mux.sv
// Return-path mux: picks PREADY/PRDATA of the addressed slave so the other
// slave's response can never influence the transfer.
module apb_slave_mux
   import apb_pkg::*;
#(
   parameter int unsigned PDATA_SIZE = 32
) (
   input  logic                  sel_i,
   input  logic                  pready_gpio_i,
   input  logic [PDATA_SIZE-1:0] prdata_gpio_i,
   input  logic                  pready_uart_i,
   input  logic [PDATA_SIZE-1:0] prdata_uart_i,
   output logic                  pready_o,
   output logic [PDATA_SIZE-1:0] prdata_o
);

   always_comb begin
      pready_o = pready_gpio_i;
      prdata_o = prdata_gpio_i;
      if (sel_i == SLV_UART) begin
         pready_o = pready_uart_i;
         prdata_o = prdata_uart_i;
      end
   end

endmodule

// File: rtl/apb_master_bridge.sv
// Command/response to APB requester for the GPIO and UART slaves, with address
// decode, PREADY wait and a timeout guard against slaves that never respond.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | cmd_ready high, waiting for a command
//   SETUP  | PSEL of the addressed slave high, PENABLE low
//   ACCESS | PSEL and PENABLE high, waiting for PREADY or timeout
//   DONE   | one-cycle rsp_valid, bus released
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int unsigned PDATA_SIZE = 32,
   parameter int unsigned SEL_BIT    = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [PDATA_SIZE-1:0] cmd_addr,
   input  logic [PDATA_SIZE-1:0] cmd_wdata,
   output logic                  rsp_valid,
   output logic [PDATA_SIZE-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  PSEL_GPIO,
   output logic                  PSEL_UART,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [PDATA_SIZE-1:0] PADDR,
   output logic [PDATA_SIZE-1:0] PWDATA,
   input  logic [PDATA_SIZE-1:0] PRDATA_GPIO,
   input  logic                  PREADY_GPIO,
   input  logic [PDATA_SIZE-1:0] PRDATA_UART,
   input  logic                  PREADY_UART
);

   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   apb_state_e             state_q, state_d;
   logic                   write_q, write_d;
   logic                   sel_q, sel_d;
   logic [SEL_BIT-1:0]     offs_q, offs_d;
   logic [PDATA_SIZE-1:0]  wdata_q, wdata_d;
   logic [PDATA_SIZE-1:0]  rdata_q, rdata_d;
   logic                   err_q, err_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic                   bus_sel;
   logic                   pready_sel;
   logic [PDATA_SIZE-1:0]  prdata_sel;

   apb_slave_mux #(.PDATA_SIZE(PDATA_SIZE)) u_slave_mux (
      .sel_i         (sel_q),
      .pready_gpio_i (PREADY_GPIO),
      .prdata_gpio_i (PRDATA_GPIO),
      .pready_uart_i (PREADY_UART),
      .prdata_uart_i (PRDATA_UART),
      .pready_o      (pready_sel),
      .prdata_o      (prdata_sel)
   );

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= ST_IDLE;
         write_q <= 1'b0;
         sel_q   <= SLV_GPIO;
         offs_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         sel_q   <= sel_d;
         offs_q  <= offs_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      write_d   = write_q;
      sel_d     = sel_q;
      offs_d    = offs_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      bus_sel   = 1'b0;
      PENABLE   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               write_d = cmd_write;
               sel_d   = cmd_addr[SEL_BIT];
               offs_d  = cmd_addr[SEL_BIT-1:0];
               wdata_d = cmd_wdata;
               rdata_d = '0;
               cnt_d   = '0;
               // Anything above the slave-select bit is outside the decoded window.
               if (|cmd_addr[PDATA_SIZE-1:SEL_BIT+1]) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  err_d   = 1'b0;
                  state_d = ST_SETUP;
               end
            end
         end
         ST_SETUP: begin
            bus_sel = 1'b1;
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            bus_sel = 1'b1;
            PENABLE = 1'b1;
            if (pready_sel) begin
               if (!write_q) rdata_d = prdata_sel;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            rsp_valid = 1'b1;
            cnt_d     = '0;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign PSEL_GPIO = bus_sel && (sel_q == SLV_GPIO);
   assign PSEL_UART = bus_sel && (sel_q == SLV_UART);
   assign PWRITE    = write_q;
   assign PADDR     = {{(PDATA_SIZE-SEL_BIT){1'b0}}, offs_q};
   assign PWDATA    = wdata_q;
   assign rsp_rdata = (state_q == ST_DONE) ? rdata_q : '0;
   assign rsp_err   = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed and random transfers
// compared cycle by cycle against a transaction-level expectation.
module tb_apb_master_bridge;

   localparam int TIMEOUT = 16;

   logic        PCLK, PRESETn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic        PSEL_GPIO, PSEL_UART, PENABLE, PWRITE;
   logic [31:0] PADDR, PWDATA;
   logic [31:0] PRDATA_GPIO, PRDATA_UART;
   logic        PREADY_GPIO, PREADY_UART;

   int checks = 0;
   int failures = 0;

   apb_master_bridge #(.PDATA_SIZE(32), .SEL_BIT(4), .TIMEOUT(TIMEOUT)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL_GPIO(PSEL_GPIO), .PSEL_UART(PSEL_UART), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA_GPIO(PRDATA_GPIO), .PREADY_GPIO(PREADY_GPIO),
      .PRDATA_UART(PRDATA_UART), .PREADY_UART(PREADY_UART)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One complete command from IDLE. lat = ACCESS cycle (1-based) in which the
   // addressed slave raises PREADY; 0 or > TIMEOUT means it never does in time.
   task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] pg,
                       input logic [31:0] pu, input int lat);
      logic        dec_err, sel, err_exp, in_bus, is_acc, is_done, rdy;
      logic [31:0] rdata_exp, paddr_exp;
      int          done_cyc;
      string       t;
      dec_err   = (addr >> 5) != 0;
      sel       = addr[4];
      paddr_exp = addr & 32'h0000_000F;
      if (dec_err) begin
         done_cyc = 1; err_exp = 1'b1;
      end else if (lat >= 1 && lat <= TIMEOUT) begin
         done_cyc = 2 + lat; err_exp = 1'b0;
      end else begin
         done_cyc = 2 + TIMEOUT; err_exp = 1'b1;
      end
      rdata_exp = (err_exp || wr) ? 32'h0 : (sel ? pu : pg);

      chk1({tag, " idle cmd_ready"}, cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
      PRDATA_GPIO = pg; PRDATA_UART = pu; PREADY_GPIO = 1'b0; PREADY_UART = 1'b0;

      for (int cyc = 1; cyc <= done_cyc; cyc++) begin
         @(posedge PCLK); #1;
         // Keep presenting junk commands while busy; they must be ignored.
         cmd_write = 1'($urandom_range(0, 1));
         cmd_addr  = $urandom;
         cmd_wdata = $urandom;
         is_done = (cyc == done_cyc);
         in_bus  = !dec_err && !is_done;
         is_acc  = in_bus && (cyc > 1);
         t = $sformatf("%s c%0d", tag, cyc);
         chk1({t, " PSEL_GPIO"}, PSEL_GPIO, in_bus && !sel);
         chk1({t, " PSEL_UART"}, PSEL_UART, in_bus && sel);
         chk1({t, " PENABLE"}, PENABLE, is_acc);
         chk1({t, " rsp_valid"}, rsp_valid, is_done);
         chk1({t, " cmd_ready"}, cmd_ready, 1'b0);
         if (in_bus) begin
            chk({t, " PADDR"}, PADDR, paddr_exp);
            chk1({t, " PWRITE"}, PWRITE, wr);
            chk({t, " PWDATA"}, PWDATA, wdata);
         end
         if (is_done) begin
            chk1({t, " rsp_err"}, rsp_err, err_exp);
            chk({t, " rsp_rdata"}, rsp_rdata, rdata_exp);
            cmd_valid = 1'b0;
            rdy = 1'b1;
         end else begin
            rdy = is_acc && ((cyc - 1) == lat);
         end
         if (sel) begin
            PREADY_UART = rdy; PREADY_GPIO = 1'($urandom_range(0, 1));
         end else begin
            PREADY_GPIO = rdy; PREADY_UART = 1'($urandom_range(0, 1));
         end
      end

      @(posedge PCLK); #1;
      chk1({tag, " after rsp_valid"}, rsp_valid, 1'b0);
      chk1({tag, " after cmd_ready"}, cmd_ready, 1'b1);
      chk1({tag, " after PSEL"}, PSEL_GPIO | PSEL_UART, 1'b0);
      PREADY_GPIO = 1'b0; PREADY_UART = 1'b0;
   endtask

   initial begin
      logic        wr;
      logic [31:0] addr;
      int          lat;

      PRESETn = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      PRDATA_GPIO = '0; PRDATA_UART = '0; PREADY_GPIO = 1'b0; PREADY_UART = 1'b0;
      repeat (2) @(posedge PCLK);
      #1;
      chk1("reset cmd_ready", cmd_ready, 1'b1);
      chk1("reset rsp_valid", rsp_valid, 1'b0);
      chk1("reset rsp_err", rsp_err, 1'b0);
      chk("reset rsp_rdata", rsp_rdata, 32'h0);
      chk1("reset PSEL_GPIO", PSEL_GPIO, 1'b0);
      chk1("reset PSEL_UART", PSEL_UART, 1'b0);
      chk1("reset PENABLE", PENABLE, 1'b0);
      chk1("reset PWRITE", PWRITE, 1'b0);
      chk("reset PADDR", PADDR, 32'h0);
      chk("reset PWDATA", PWDATA, 32'h0);
      PRESETn = 1'b1;
      @(posedge PCLK); #1;

      xfer("wr_gpio", 1'b1, 32'h01, 32'h0000_00FF, 32'h1234_5678, 32'h8765_4321, 2);
      xfer("rd_gpio", 1'b0, 32'h00, 32'h0, 32'hA5A5_0F0F, 32'h5A5A_F0F0, 2);
      xfer("rd_uart", 1'b0, 32'h12, 32'h0, 32'h1111_2222, 32'hC0DE_BEEF, 1);
      xfer("wr_uart", 1'b1, 32'h1F, 32'hDEAD_0001, 32'h0, 32'h0, 3);
      xfer("dec_err", 1'b0, 32'h40, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      xfer("dec_err_hi", 1'b1, 32'h8000_0003, 32'h55, 32'h0, 32'h0, 1);
      xfer("timeout", 1'b0, 32'h03, 32'h0, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 0);
      xfer("ready_at_limit", 1'b0, 32'h15, 32'h0, 32'h0101_0101, 32'h7777_0000, TIMEOUT);
      xfer("ready_past_limit", 1'b0, 32'h15, 32'h0, 32'h0101_0101, 32'h7777_0000, TIMEOUT + 1);

      // Abort a UART read in its second ACCESS cycle with an asynchronous reset.
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h12; cmd_wdata = 32'h0;
      PREADY_GPIO = 1'b0; PREADY_UART = 1'b0;
      @(posedge PCLK); #1;
      cmd_valid = 1'b0;
      repeat (2) begin
         @(posedge PCLK); #1;
      end
      chk1("abort pre PSEL_UART", PSEL_UART, 1'b1);
      chk1("abort pre PENABLE", PENABLE, 1'b1);
      #2 PRESETn = 1'b0;
      #1;
      chk1("abort PSEL_UART", PSEL_UART, 1'b0);
      chk1("abort PENABLE", PENABLE, 1'b0);
      chk1("abort cmd_ready", cmd_ready, 1'b1);
      @(negedge PCLK);
      PRESETn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge PCLK); #1;
         chk1($sformatf("abort post%0d rsp_valid", i), rsp_valid, 1'b0);
         chk1($sformatf("abort post%0d cmd_ready", i), cmd_ready, 1'b1);
      end
      xfer("wr_after_abort", 1'b1, 32'h01, 32'h0000_0042, 32'h0, 32'h0, 2);

      for (int n = 0; n < 40; n++) begin
         wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0)
            addr = 32'($urandom_range(0, 31)) | (32'h1 << $urandom_range(5, 31));
         else
            addr = 32'($urandom_range(0, 31));
         if ($urandom_range(0, 9) == 0) lat = 0;
         else lat = $urandom_range(1, 5);
         xfer($sformatf("rnd%0d", n), wr, addr, $urandom, $urandom, $urandom, lat);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream APB requester for the peripheral subsystem. It converts a simple command/response interface, driven by the test host or CPU glue, into APB transfers to the GPIO slave and the UART slave.
- Owns the address decode, the per-slave PSEL generation, the IDLE/SETUP/ACCESS sequencing, the PREADY wait and a timeout guard for slaves that never assert PREADY.

Parameters:
- PDATA_SIZE, 32, width of the data and address buses; must be a multiple of 8.
- SEL_BIT, 4, address bit that selects the slave: 0 = GPIO, 1 = UART.
- TIMEOUT, 16, maximum number of ACCESS cycles to wait for PREADY; 0 disables the timeout.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  PDATA_SIZE  byte/register address.
- cmd_wdata  in  PDATA_SIZE  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  PDATA_SIZE  read data; 0 for writes and for errors.
- rsp_err  out  1  decode error or timeout; valid with rsp_valid.
- PSEL_GPIO  out  1  APB select, GPIO slave.
- PSEL_UART  out  1  APB select, UART slave.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  PDATA_SIZE  APB address; register offset = cmd_addr[SEL_BIT-1:0], zero-extended.
- PWDATA  out  PDATA_SIZE  APB write data.
- PRDATA_GPIO  in  PDATA_SIZE  read data from GPIO.
- PREADY_GPIO  in  1  ready from GPIO.
- PRDATA_UART  in  PDATA_SIZE  read data from UART.
- PREADY_UART  in  1  ready from UART.

Behaviour:
- Reset (PRESETn low, asynchronous): state = IDLE.
  - All outputs 0, except cmd_ready = 1.
  - PADDR, PWDATA, PWRITE = 0; timeout counter = 0.
- States and transitions:
  - IDLE: cmd_ready = 1. A handshake (cmd_valid & cmd_ready) at a PCLK edge latches write, addr and wdata.
    - Legal address: go to SETUP.
    - Decode error (cmd_addr[PDATA_SIZE-1:SEL_BIT+1] != 0): go to DONE with rsp_err = 1. No PSEL is asserted.
  - SETUP (1 cycle): selected PSEL = 1, PENABLE = 0, PADDR/PWRITE/PWDATA driven from the latched values. Next state is ACCESS.
  - ACCESS: PSEL and PENABLE = 1. Each edge samples the selected slave's PREADY.
    - PREADY = 1: capture the selected PRDATA (reads only), go to DONE.
    - Otherwise the counter increments. When the counter reaches TIMEOUT (TIMEOUT != 0), go to DONE with rsp_err = 1 and rsp_rdata = 0.
  - DONE (1 cycle): rsp_valid = 1, PSEL = 0, PENABLE = 0, cmd_ready = 0. Next state is IDLE and the counter clears.
- The PREADY and PRDATA of the non-selected slave are ignored.
- Only one PSEL is ever high, and only in SETUP and ACCESS. PENABLE is never high without a PSEL.
- Latency, command accept to rsp_valid: 2 + N cycles, where N = number of ACCESS cycles (N >= 1). GPIO is registered-ready, so it completes with N = 2, giving 4 cycles.
- Throughput: at most one command per 4 cycles; the IDLE cycle between transfers is mandatory.
- cmd_* inputs are ignored while cmd_ready = 0. rsp_valid has no backpressure.
- PADDR, PWRITE and PWDATA hold stable from SETUP through the end of ACCESS.
- Reset asserted mid-transfer: bus signals drop immediately (asynchronously). No rsp_valid is emitted for the aborted command.
- Timeout does not retry; a slave that asserts PREADY after a timeout is ignored.

Decomposition:
- Shared package apb_pkg holds:
  - the state encoding (IDLE, SETUP, ACCESS, DONE);
  - slave index constants SLV_GPIO = 0 and SLV_UART = 1;
  - the GPIO register offsets DATA = 0 and DIRECTION = 1.
- One sub-module, apb_slave_mux: combinational selection of PREADY/PRDATA by slave index. All sequencing stays in the top module.

Test Plan:
- Write GPIO: cmd_addr = 0x01, wdata = 0x0000_00FF.
  - SETUP: PSEL_GPIO = 1, PENABLE = 0, PADDR = 1, PWRITE = 1.
  - PREADY_GPIO arrives in the 2nd ACCESS cycle; rsp_valid 4 cycles after accept, rsp_err = 0.
  - PSEL_UART stays 0 throughout.
- Read GPIO: cmd_addr = 0x00, PRDATA_GPIO = 0xA5A5_0F0F.
  - rsp_rdata = 0xA5A5_0F0F, rsp_err = 0, PWRITE = 0 throughout.
- UART select: cmd_addr = 0x12 → PSEL_UART = 1 and PADDR = 0x2. A read returns PRDATA_UART, not PRDATA_GPIO.
- Decode error: cmd_addr = 0x40 → no PSEL or PENABLE activity; rsp_valid 1 cycle after accept with rsp_err = 1 and rsp_rdata = 0.
- Timeout: PREADY held 0 with TIMEOUT = 16 → rsp_err = 1 after 16 ACCESS cycles. A PREADY pulse one cycle later produces no second rsp_valid.
- Reset during ACCESS: PRESETn pulsed low mid-cycle → PSEL and PENABLE fall before the next edge, no rsp_valid, and cmd_ready = 1 after release. A following write completes normally.
